crypto_test_buffer_memory: RTL and testbench



---
 rtl/crypto_test_buffer_memory_if.sv | 27 ++
 rtl/crypto_test_buffer_memory.sv | 145 ++++++++++++++
 tb/tb_crypto_test_buffer_memory.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crypto_test_buffer_memory_if.sv
// rtl/crypto_test_buffer_memory_if.sv - Avalon-MM slave port bundle for the crypto test buffer memory
interface crypto_test_buffer_memory_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);
   localparam int BYTE_LANES = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] address;
   logic                  chipselect;
   logic                  read;
   logic                  write;
   logic [BYTE_LANES-1:0] byteenable;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH-1:0] readdata;
   logic                  readdatavalid;
   logic                  waitrequest;

   modport master (
      output address, chipselect, read, write, byteenable, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, chipselect, read, write, byteenable, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/crypto_test_buffer_memory.sv
// rtl/crypto_test_buffer_memory.sv - dual-port byte-lane buffer RAM with read pipeline and wipe sequencer
module crypto_test_buffer_memory #(
   parameter int    DATA_WIDTH   = 32,
   parameter int    ADDR_WIDTH   = 12,
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = "crypto_test_buffer_memory.hex"
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clken,
   input  logic                      reset_req,
   crypto_test_buffer_memory_if.slave p1,
   crypto_test_buffer_memory_if.slave p2,
   input  logic                      wipe_start,
   output logic                      wipe_busy,
   output logic                      wipe_done
);
   localparam int BYTE_LANES = DATA_WIDTH / 8;
   localparam int DEPTH      = 2 ** ADDR_WIDTH;

   typedef enum logic {IDLE, WIPE} wipe_state_t;

   // Power-up contents are attached by the memory-generation flow from INIT_FILE;
   // with an empty name the array powers up undefined until written or wiped.
   if (INIT_FILE == "") begin : g_blank_power_up
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  clocken;
   logic                  stall_all;
   logic                  collision;
   logic [1:0]            cs, rd, wr, wait_req, rd_acc, wr_acc;
   logic [ADDR_WIDTH-1:0] addr  [2];
   logic [BYTE_LANES-1:0] be    [2];
   logic [DATA_WIDTH-1:0] wdata [2];

   wipe_state_t           state, state_nx;
   logic [ADDR_WIDTH-1:0] wipe_cnt, wipe_cnt_nx;
   logic                  done_nx;
   logic                  wipe_en;

   logic [1:0]            s1_v, s2_v;
   logic [DATA_WIDTH-1:0] s1_data [2];
   logic [DATA_WIDTH-1:0] s2_data [2];

   assign clocken  = clken & ~reset_req;
   assign cs       = {p2.chipselect, p1.chipselect};
   assign rd       = {p2.read, p1.read};
   assign wr       = {p2.write, p1.write};
   assign addr[0]  = p1.address;
   assign addr[1]  = p2.address;
   assign be[0]    = p1.byteenable;
   assign be[1]    = p2.byteenable;
   assign wdata[0] = p1.writedata;
   assign wdata[1] = p2.writedata;

   // Same-address write clash: port 1 wins, port 2 is held off and retries.
   assign collision = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);
   assign stall_all = reset | wipe_busy | ~clocken;
   assign wait_req  = {stall_all | collision, stall_all};
   assign wr_acc    = cs & wr & ~wait_req;
   assign rd_acc    = cs & rd & ~wr & ~wait_req;

   assign wipe_busy = (state == WIPE);
   assign wipe_en   = wipe_busy & clocken & ~reset;

   always_comb begin
      state_nx    = state;
      wipe_cnt_nx = wipe_cnt;
      done_nx     = 1'b0;
      if (clocken) begin
         case (state)
            IDLE: begin
               if (wipe_start) begin
                  state_nx    = WIPE;
                  wipe_cnt_nx = '0;
               end
            end
            WIPE: begin
               wipe_cnt_nx = wipe_cnt + 1'b1;
               if (&wipe_cnt) begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wipe_cnt  <= '0;
         wipe_done <= 1'b0;
      end else begin
         state     <= state_nx;
         wipe_cnt  <= wipe_cnt_nx;
         wipe_done <= done_nx;
      end
   end

   // Array has no reset; a wipe cut short by reset leaves it partially zeroed.
   always_ff @(posedge clk) begin
      if (wipe_en) begin
         mem[wipe_cnt] <= '0;
      end
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < BYTE_LANES; i++) begin
            if (wr_acc[p] && be[p][i]) begin
               mem[addr[p]][8*i +: 8] <= wdata[p][8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_v <= '0;
         s2_v <= '0;
         for (int p = 0; p < 2; p++) begin
            s1_data[p] <= '0;
            s2_data[p] <= '0;
         end
      end else if (clocken) begin
         s1_v <= rd_acc;
         s2_v <= s1_v;
         for (int p = 0; p < 2; p++) begin
            if (rd_acc[p]) begin
               s1_data[p] <= mem[addr[p]];
            end
            s2_data[p] <= s1_data[p];
         end
      end
   end

   // A held pipeline stage is masked while stalled and reappears once clocken returns.
   assign p1.waitrequest   = wait_req[0];
   assign p2.waitrequest   = wait_req[1];
   assign p1.readdatavalid = ((READ_LATENCY == 2) ? s2_v[0] : s1_v[0]) & clocken;
   assign p2.readdatavalid = ((READ_LATENCY == 2) ? s2_v[1] : s1_v[1]) & clocken;
   assign p1.readdata      = (READ_LATENCY == 2) ? s2_data[0] : s1_data[0];
   assign p2.readdata      = (READ_LATENCY == 2) ? s2_data[1] : s1_data[1];
endmodule

// File: tb/tb_crypto_test_buffer_memory.sv
// tb/tb_crypto_test_buffer_memory.sv - scoreboard bench driving latency-2 and latency-1 instances in lockstep
module tb_crypto_test_buffer_memory;
   localparam int DW    = 32;
   localparam int AW    = 8;
   localparam int DEPTH = 1 << AW;
   localparam int BL    = DW / 8;

   typedef struct {
      logic [DW-1:0] data;
      int            edge_no;
   } exp_t;

   logic          clk        = 1'b0;
   logic          reset      = 1'b1;
   logic          clken      = 1'b1;
   logic          reset_req  = 1'b0;
   logic          wipe_start = 1'b0;
   logic [1:0]    p_cs       = '0;
   logic [1:0]    p_rd       = '0;
   logic [1:0]    p_wr       = '0;
   logic [AW-1:0] p_addr [2];
   logic [BL-1:0] p_be   [2];
   logic [DW-1:0] p_wd   [2];
   logic [3:0]    m_wait, m_valid;
   logic [DW-1:0] m_data [4];
   logic [1:0]    wbusy, wdone;
   logic [DW-1:0] model  [DEPTH];
   exp_t          q      [4][$];
   int            tests  = 0;
   int            fails  = 0;
   int            ce_cnt = 0;
   int            done_cnt [2];
   bit            mon_en = 1'b0;

   always #5 clk = ~clk;

   crypto_test_buffer_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifs [4] ();

   for (genvar g = 0; g < 4; g++) begin : g_ports
      assign ifs[g].address    = p_addr[g % 2];
      assign ifs[g].chipselect = p_cs[g % 2];
      assign ifs[g].read       = p_rd[g % 2];
      assign ifs[g].write      = p_wr[g % 2];
      assign ifs[g].byteenable = p_be[g % 2];
      assign ifs[g].writedata  = p_wd[g % 2];
      assign m_wait[g]         = ifs[g].waitrequest;
      assign m_valid[g]        = ifs[g].readdatavalid;
      assign m_data[g]         = ifs[g].readdata;
   end

   crypto_test_buffer_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .INIT_FILE("")) dut (
      .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
      .p1(ifs[0]), .p2(ifs[1]),
      .wipe_start(wipe_start), .wipe_busy(wbusy[0]), .wipe_done(wdone[0])
   );

   crypto_test_buffer_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_FILE("")) dut_rl1 (
      .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
      .p1(ifs[2]), .p2(ifs[3]),
      .wipe_start(wipe_start), .wipe_busy(wbusy[1]), .wipe_done(wdone[1])
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: indices 0,1 are the latency-2 instance, 2,3 the latency-1 instance.
   task automatic mon_chk(input int k);
      exp_t e;
      if (!m_valid[k]) return;
      chk("valid_only_with_clocken", {31'd0, clken & ~reset_req}, 1);
      chk($sformatf("valid_expected_%0d", k), {31'd0, q[k].size() != 0}, 1);
      if (q[k].size() == 0) return;
      e = q[k].pop_front();
      chk($sformatf("rdata_%0d", k), m_data[k], e.data);
      chk($sformatf("latency_%0d", k), ce_cnt, e.edge_no + ((k < 2) ? 2 : 1) - 1);
   endtask

   always @(posedge clk) if (clken && !reset_req) ce_cnt++;

   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < 4; k++) mon_chk(k);
         for (int d = 0; d < 2; d++) if (wdone[d]) done_cnt[d]++;
      end
   end

   task automatic idle();
      p_cs = '0;
      p_rd = '0;
      p_wr = '0;
   endtask

   task automatic set_port(input int p, input logic r, input logic w, input int a,
                           input logic [BL-1:0] b, input logic [DW-1:0] d);
      p_cs[p]   = 1'b1;
      p_rd[p]   = r;
      p_wr[p]   = w;
      p_addr[p] = AW'(a);
      p_be[p]   = b;
      p_wd[p]   = d;
   endtask

   // One bus cycle: check handshake, queue expected reads, then commit writes to the model.
   task automatic step();
      logic       ce, coll;
      logic [1:0] ewr, acc;
      @(negedge clk);
      ce     = clken & ~reset_req;
      coll   = p_cs[0] & p_wr[0] & p_cs[1] & p_wr[1] & (p_addr[0] == p_addr[1]);
      ewr[0] = reset | ~ce;
      ewr[1] = reset | ~ce | coll;
      for (int k = 0; k < 4; k++) chk($sformatf("waitrequest_%0d", k), {31'd0, m_wait[k]}, {31'd0, ewr[k % 2]});
      for (int p = 0; p < 2; p++) begin
         acc[p] = p_cs[p] & (p_rd[p] | p_wr[p]) & ~ewr[p];
         if (acc[p] && !p_wr[p]) begin
            q[p].push_back('{model[p_addr[p]], ce_cnt + 1});
            q[p + 2].push_back('{model[p_addr[p]], ce_cnt + 1});
         end
      end
      for (int p = 0; p < 2; p++) begin
         if (acc[p] && p_wr[p]) begin
            for (int i = 0; i < BL; i++) if (p_be[p][i]) model[p_addr[p]][8*i +: 8] = p_wd[p][8*i +: 8];
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      idle();
      repeat (n) step();
   endtask

   task automatic fill();
      for (int i = 0; i < DEPTH / 2; i++) begin
         set_port(0, 1'b0, 1'b1, 2 * i, '1, $urandom | 32'h01010101);
         set_port(1, 1'b0, 1'b1, 2 * i + 1, '1, $urandom | 32'h01010101);
         step();
      end
      idle();
   endtask

   task automatic read_all();
      for (int i = 0; i < DEPTH / 2; i++) begin
         set_port(0, 1'b1, 1'b0, 2 * i, '1, '0);
         set_port(1, 1'b1, 1'b0, 2 * i + 1, '1, '0);
         step();
      end
      drain(4);
   endtask

   task automatic do_wipe(input int stall_at, input int exp_busy, input logic [1:0] rd_en);
      int         busy_n [2];
      int         done0  [2];
      int         wait_bad, fall_bad;
      logic [1:0] prev;
      busy_n   = '{0, 0};
      done0    = done_cnt;
      wait_bad = 0;
      fall_bad = 0;
      prev     = '0;
      idle();
      for (int p = 0; p < 2; p++) if (rd_en[p]) set_port(p, 1'b1, 1'b0, 20 + p, '1, '0);
      wipe_start = 1'b1;
      step();
      wipe_start = 1'b0;
      idle();
      for (int i = 0; i < DEPTH + 30; i++) begin
         reset_req = (stall_at >= 0) && (i >= stall_at) && (i < stall_at + 3);
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (wbusy[d]) begin
               busy_n[d]++;
               if (!(m_wait[2*d] && m_wait[2*d+1])) wait_bad++;
            end
            if (wdone[d] && (wbusy[d] || !prev[d])) fall_bad++;
         end
         if (reset_req) chk("no_valid_in_stall", {28'd0, m_valid}, 0);
         prev = wbusy;
         @(posedge clk);
         #1;
      end
      reset_req = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("wipe_busy_cycles_%0d", d), busy_n[d], exp_busy);
         chk($sformatf("wipe_done_pulses_%0d", d), done_cnt[d] - done0[d], 1);
      end
      chk("wipe_waitrequest_held", wait_bad, 0);
      chk("wipe_done_on_busy_fall", fall_bad, 0);
      for (int a = 0; a < DEPTH; a++) model[a] = '0;
   endtask

   initial begin
      int d0 [2];
      for (int p = 0; p < 2; p++) begin
         p_addr[p] = '0;
         p_be[p]   = '1;
         p_wd[p]   = '0;
      end
      done_cnt = '{0, 0};
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk("reset_valid", {31'd0, m_valid[k]}, 0);
         chk("reset_rdata", m_data[k], 0);
         chk("reset_waitrequest", {31'd0, m_wait[k]}, 1);
      end
      chk("reset_wipe_busy", {30'd0, wbusy}, 0);
      chk("reset_wipe_done", {30'd0, wdone}, 0);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      fill();

      set_port(0, 1'b0, 1'b1, 5, '1, 32'h11223344);
      step();
      idle();
      set_port(1, 1'b0, 1'b1, 5, 4'b0101, 32'hAABBCCDD);
      step();
      idle();
      set_port(0, 1'b1, 1'b0, 5, '1, '0);
      set_port(1, 1'b1, 1'b0, 5, '1, '0);
      step();
      drain(4);

      set_port(0, 1'b0, 1'b1, 7, '1, 32'hDEADBEEF);
      set_port(1, 1'b0, 1'b1, 7, '1, 32'h01020304);
      step();
      p_cs[0] = 1'b0;
      step();
      idle();
      set_port(0, 1'b1, 1'b0, 7, '1, '0);
      step();
      drain(4);

      set_port(0, 1'b0, 1'b1, 9, '1, 32'h5);
      step();
      set_port(0, 1'b0, 1'b1, 9, '1, 32'h6);
      set_port(1, 1'b1, 1'b0, 9, '1, '0);
      step();
      idle();
      set_port(1, 1'b1, 1'b0, 9, '1, '0);
      step();
      drain(4);

      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < 2; p++) begin
            p_cs[p]   = ($urandom_range(0, 3) != 0);
            p_rd[p]   = $urandom_range(0, 1);
            p_wr[p]   = $urandom_range(0, 1);
            p_addr[p] = AW'($urandom_range(0, 15));
            p_be[p]   = BL'($urandom);
            p_wd[p]   = $urandom;
         end
         clken     = ($urandom_range(0, 9) != 0);
         reset_req = ($urandom_range(0, 14) == 0);
         step();
      end
      clken     = 1'b1;
      reset_req = 1'b0;
      drain(4);
      read_all();

      do_wipe(-1, DEPTH, 2'b00);
      read_all();

      fill();
      do_wipe(0, DEPTH + 3, 2'b11);
      read_all();

      fill();
      d0 = done_cnt;
      wipe_start = 1'b1;
      step();
      wipe_start = 1'b0;
      idle();
      repeat (100) begin
         @(negedge clk);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("busy_before_reset", {30'd0, wbusy}, 32'd3);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("busy_after_reset", {30'd0, wbusy}, 0);
      for (int d = 0; d < 2; d++) chk($sformatf("no_done_after_reset_%0d", d), done_cnt[d] - d0[d], 0);
      for (int a = 0; a < 100; a++) model[a] = '0;
      @(posedge clk);
      #1;
      read_all();

      drain(6);
      for (int k = 0; k < 4; k++) chk($sformatf("queue_drained_%0d", k), q[k].size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
